// File: rtl/sb_pkg.sv
// Shared types and width constants for the MEM-stage store buffer.
// The entry layout is fixed by SB_AW/SB_DW; DEPTH-dependent widths come from sb_ptr_w().
package sb_pkg;

  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic              valid;
    logic [SB_AW-1:2]  waddr;
    logic [SB_DW-1:0]  data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match select: walks entries from head (oldest) toward tail so the
// last hit seen is the youngest buffered store to the load's word address.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PTR_W = sb_ptr_w(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [SB_AW-1:2]  ld_waddr,
  output logic              hit,
  output logic [SB_DW-1:0]  data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && entries[idx].valid &&
          (entries[idx].waddr == ld_waddr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_load_forward.sv
// Word-granular MEM-stage store buffer: in-order retire over req/ack and
// store-to-load forwarding. Define SB_LOAD_FORWARD_EN to forward; otherwise matching loads stall.
module store_load_forward
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic          fence,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          stall,
  output logic          empty,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack
);

  localparam int PTR_W = sb_ptr_w(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full;
  logic             enq;
  logic             ret;
  logic             match_hit;
  logic [DW-1:0]    match_data;
  logic             ld_hazard;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_req   = !empty;
  assign ret       = mem_req && mem_ack;
  // No enqueue while draining; a full buffer never writes through.
  assign enq       = st_valid && !full && !fence;
  assign mem_addr  = {entries_q[head_q].waddr, 2'b00};
  assign mem_wdata = entries_q[head_q].data;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (ret) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PTR_W'(1);
    end
    if (enq) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].waddr = st_addr[AW-1:2];
      entries_d[tail_q].data  = st_data;
      tail_d = tail_q + PTR_W'(1);
    end
    case ({enq, ret})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  // Compares against registered contents only, so a same-cycle store is never seen.
  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries_q),
    .head     (head_q),
    .count    (count_q),
    .ld_waddr (ld_addr[AW-1:2]),
    .hit      (match_hit),
    .data     (match_data)
  );

`ifdef SB_LOAD_FORWARD_EN
  assign fwd_hit   = ld_valid && match_hit;
  assign fwd_data  = fwd_hit ? match_data : '0;
  assign ld_hazard = 1'b0;
`else
  logic unused_match_data;
  assign unused_match_data = ^match_data;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
  assign ld_hazard = ld_valid && match_hit;
`endif

  assign stall = (st_valid && full) || (fence && !empty) || ld_hazard;

endmodule
